sram_arbiter_2c: RTL and testbench
==================================

Name: sram_arbiter_2c

Overview:
- Shares one 128x32 1R1W SRAM between two requesters, client 0 and client 1. Example pairing: forward-elimination unit and back-substitution unit of the tridiagonal solver.
- Independent round-robin arbitration on the write port and the read port.
- Registers the address, data and enable going to the SRAM, and returns read data with fixed latency, tagged per client.
- Sits between the solver datapath units and the SRAM macro, whose 4 ns input and output delays require registered drive and registered capture.

Parameters:
ADDR_W, 7, SRAM address width (128 words)
DATA_W, 32, SRAM word width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr_req  in  2  per-client write request (bit i = client i)
wr_addr0, wr_addr1  in  ADDR_W  write address, clients 0/1
wr_data0, wr_data1  in  DATA_W  write data, clients 0/1
wr_gnt  out  2  write grant, combinational, one-hot or zero
rd_req  in  2  per-client read request
rd_addr0, rd_addr1  in  ADDR_W  read address, clients 0/1
rd_gnt  out  2  read grant, combinational, one-hot or zero
rd_valid  out  2  read data valid, one cycle pulse per grant
rd_data  out  DATA_W  read data (shared bus, owner given by rd_valid)
sram_we  out  1  SRAM write enable
sram_waddr  out  ADDR_W  SRAM write address
sram_wdata  out  DATA_W  SRAM write data
sram_raddr  out  ADDR_W  SRAM read address
sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - Outputs: sram_we=0, sram_waddr=0, sram_wdata=0, sram_raddr=0, rd_valid=0, rd_data=0.
  - Pointers: wr_ptr=0 and rd_ptr=0, meaning client 0 has priority.
  - In-flight reads are discarded and no rd_valid is produced for them.
- Grant rule, each port independently; the transfer happens in the cycle req & gnt is high:
  - Only client i requests: gnt[i]=1.
  - Both request: grant goes to the client at ptr.
  - Neither requests: gnt=0.
  - Grants do not depend on downstream state. There is no backpressure and every cycle can grant.
- Pointer update: after any grant to client i, ptr <= ~i. Under continuous contention the grants alternate, so the maximum wait is 1 cycle.
- Write path:
  - Grant in cycle N: at edge end-of-N, register sram_we=1 plus the granted address and data.
  - SRAM commits at edge end-of-N+1.
  - With no grant in N, sram_we=0 in N+1. Address and data hold their last values.
- Read path:
  - Grant in cycle N: sram_raddr <= granted address at end-of-N. sram_raddr holds when there is no grant.
  - At end-of-N+1: rd_data <= sram_rdata, and rd_valid[i] <= 1 for cycle N+2 only. Latency is 2 cycles from grant to valid.
  - A 2-entry owner shift register carries the client tag. Back-to-back reads produce back-to-back valids in order.
  - rd_data holds its value when rd_valid=0.
- Ordering and hazards:
  - A read returns the data of every write granted in a strictly earlier cycle.
  - A read granted in the same cycle as a write to the same address returns the old word.
  - The block does no forwarding.
- Write and read ports are independent. Both may be granted in the same cycle, to any clients.
- Reset mid-operation: all pipeline state clears at once. Grants remain purely combinational from req and ptr=0.

Test Plan:
1. Reset, then client 0 writes addr 5 = 0xDEADBEEF in cycle 1 -> sram_we=1, sram_waddr=5, sram_wdata=0xDEADBEEF in cycle 2. Client 1 reads addr 5 in cycle 3 -> rd_valid=2'b10, rd_data=0xDEADBEEF in cycle 5.
2. Both clients hold rd_req for 6 cycles after reset -> rd_gnt sequence 01,10,01,10,01,10. rd_valid follows the same sequence 2 cycles later, and each rd_data matches its client's address contents.
3. Both write continuously after reset, client 0 to addr 1 and client 1 to addr 2 -> wr_gnt alternates 01,10,…. sram_waddr alternates 1,2, one cycle delayed.
4. Same cycle: write addr 9 = 0x1 (old value 0x7) and read addr 9 -> read returns 0x7. Read of addr 9 one cycle later returns 0x1.
5. Read granted, reset_n pulsed low in the next cycle -> rd_valid stays 0, all sram_* outputs are 0, and ptr returns to client 0 (both requesting -> client 0 granted first).
6. Single requester: client 1 issues reads every cycle while client 0 is idle -> rd_gnt=10 every cycle with no bubbles, and there is one rd_valid per grant.

Source files
------------

// File: rtl/sram_arbiter_2c.sv
// Two-client round-robin arbiter for a 1R1W SRAM with registered macro drive.
// Independent write and read ports; read data returns two cycles after grant, tagged per client.
module sram_arbiter_2c #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Pointer value names the client that wins the next tie.
  logic       wrPtr;
  logic       rdPtr;
  logic [1:0] rdOwnerS1;

  function automatic logic [1:0] arbitrate(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

  always_comb begin
    wr_gnt = arbitrate(wr_req, wrPtr);
    rd_gnt = arbitrate(rd_req, rdPtr);
  end

  // Write port: register enable, address and data toward the macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr      <= 1'b0;
      sram_we    <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
    end else begin
      sram_we <= |wr_gnt;
      if (|wr_gnt) begin
        wrPtr      <= wr_gnt[0];
        sram_waddr <= wr_gnt[1] ? wr_addr1 : wr_addr0;
        sram_wdata <= wr_gnt[1] ? wr_data1 : wr_data0;
      end
    end
  end

  // Read port: register address, then carry the owner tag alongside the macro access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr      <= 1'b0;
      sram_raddr <= '0;
      rdOwnerS1  <= 2'b00;
      rd_valid   <= 2'b00;
      rd_data    <= '0;
    end else begin
      rdOwnerS1 <= rd_gnt;
      rd_valid  <= rdOwnerS1;
      if (|rd_gnt) begin
        rdPtr      <= rd_gnt[0];
        sram_raddr <= rd_gnt[1] ? rd_addr1 : rd_addr0;
      end
      if (|rdOwnerS1) begin
        rd_data <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter_2c.sv
// Self-checking bench for sram_arbiter_2c: directed vectors, corner sequences and random traffic
// compared against a transaction-level model (golden memory plus a queue of pending read returns).
module tb_sram_arbiter_2c;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 128;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1;
  logic [DATA_W-1:0] wr_data0, wr_data1;
  logic [1:0]        wr_gnt;
  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1;
  logic [1:0]        rd_gnt;
  logic [1:0]        rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_waddr;
  logic [DATA_W-1:0] sram_wdata;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;

  sram_arbiter_2c #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // SRAM macro model: write commits at the edge, read is asynchronous from the registered address.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) if (sram_we) mem[sram_waddr] <= sram_wdata;
  assign sram_rdata = mem[sram_raddr];

  typedef struct {
    logic [1:0]        wrReq;
    logic [1:0]        rdReq;
    logic [ADDR_W-1:0] wa0, wa1, ra0, ra1;
    logic [DATA_W-1:0] wd0, wd1;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [1:0] expWg;
    logic [1:0] expRg;
  } vec_t;

  typedef struct {
    logic              owner;
    logic [DATA_W-1:0] data;
    int                due;
  } rdRet_t;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [DATA_W-1:0] gold [DEPTH];
  rdRet_t            pendQ[$];
  logic              mWrPrio, mRdPrio;
  logic              expWe;
  logic [ADDR_W-1:0] expWaddr, expRaddr;
  logic [DATA_W-1:0] expWdata, expRdData;
  logic [1:0]        expRdValid;
  int                cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    else nPass++;
  endtask

  function automatic logic [1:0] refGrant(input logic [1:0] req, input logic prio);
    if (req == 2'b11) return prio ? 2'b10 : 2'b01;
    return req;
  endfunction

  task automatic chkRegs();
    chk("sram_we",    32'(sram_we),    32'(expWe));
    chk("sram_waddr", 32'(sram_waddr), 32'(expWaddr));
    chk("sram_wdata", sram_wdata,      expWdata);
    chk("sram_raddr", 32'(sram_raddr), 32'(expRaddr));
    chk("rd_valid",   32'(rd_valid),   32'(expRdValid));
    chk("rd_data",    rd_data,         expRdData);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // One clock cycle: drive, check grants, advance model and DUT, check registered outputs.
  task automatic cycle(input stim_t s, output logic [1:0] wg, output logic [1:0] rg);
    logic [1:0] ewg, erg;
    logic [ADDR_W-1:0] a;
    rdRet_t r;
    wr_req = s.wrReq; wr_addr0 = s.wa0; wr_addr1 = s.wa1; wr_data0 = s.wd0; wr_data1 = s.wd1;
    rd_req = s.rdReq; rd_addr0 = s.ra0; rd_addr1 = s.ra1;
    #1;
    ewg = refGrant(s.wrReq, mWrPrio);
    erg = refGrant(s.rdReq, mRdPrio);
    chk("wr_gnt", 32'(wr_gnt), 32'(ewg));
    chk("rd_gnt", 32'(rd_gnt), 32'(erg));
    wg = wr_gnt;
    rg = rd_gnt;
    // Reads see only writes from strictly earlier cycles, so sample gold before this cycle's write.
    if (erg != 2'b00) begin
      a = erg[1] ? s.ra1 : s.ra0;
      r.owner = erg[1];
      r.data  = gold[a];
      r.due   = cyc + 2;
      pendQ.push_back(r);
      expRaddr = a;
      mRdPrio  = erg[0];
    end
    expWe = (ewg != 2'b00);
    if (expWe) begin
      expWaddr = ewg[1] ? s.wa1 : s.wa0;
      expWdata = ewg[1] ? s.wd1 : s.wd0;
      gold[expWaddr] = expWdata;
      mWrPrio = ewg[0];
    end
    @(posedge clock); #1;
    cyc++;
    expRdValid = 2'b00;
    if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      r = pendQ.pop_front();
      expRdValid = r.owner ? 2'b10 : 2'b01;
      expRdData  = r.data;
    end
    chkRegs();
  endtask

  // Asynchronous reset pulse; caller guarantees no write is in flight.
  task automatic doReset();
    wr_req = 2'b00; rd_req = 2'b00;
    reset_n = 1'b0;
    #2;
    pendQ.delete();
    mWrPrio = 1'b0; mRdPrio = 1'b0;
    expWe = 1'b0; expWaddr = '0; expWdata = '0; expRaddr = '0;
    expRdValid = 2'b00; expRdData = '0;
    chkRegs();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    cyc = 0;
  endtask

  vec_t vecs[8];

  initial begin
    stim_t s;
    logic [1:0] wg, rg;

    // Contention table: both clients on both ports, grants alternate from client 0.
    for (int i = 0; i < 6; i++) begin
      vecs[i].s = idle();
      vecs[i].s.wrReq = 2'b11; vecs[i].s.wa0 = 7'd1; vecs[i].s.wa1 = 7'd2;
      vecs[i].s.wd0 = 32'h1000_0000 + 32'(i); vecs[i].s.wd1 = 32'h2000_0000 + 32'(i);
      vecs[i].s.rdReq = 2'b11; vecs[i].s.ra0 = 7'd3; vecs[i].s.ra1 = 7'd4;
      vecs[i].expWg = (i % 2 == 0) ? 2'b01 : 2'b10;
      vecs[i].expRg = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    for (int i = 6; i < 8; i++) begin
      vecs[i].s = idle();
      vecs[i].expWg = 2'b00;
      vecs[i].expRg = 2'b00;
    end

    wr_req = 2'b00; rd_req = 2'b00;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    cyc = 0;
    doReset();

    // Client 0 writes, client 1 reads it back two cycles after grant.
    s = idle(); s.wrReq = 2'b01; s.wa0 = 7'd5; s.wd0 = 32'hDEAD_BEEF;
    cycle(s, wg, rg);
    chk("t1_we",    32'(sram_we),    32'd1);
    chk("t1_waddr", 32'(sram_waddr), 32'd5);
    chk("t1_wdata", sram_wdata,      32'hDEAD_BEEF);
    cycle(idle(), wg, rg);
    s = idle(); s.rdReq = 2'b10; s.ra1 = 7'd5;
    cycle(s, wg, rg);
    cycle(idle(), wg, rg);
    chk("t1_rd_valid", 32'(rd_valid), 32'h2);
    chk("t1_rd_data",  rd_data,       32'hDEAD_BEEF);

    // Define every word through the write port.
    for (int a = 0; a < int'(DEPTH); a++) begin
      s = idle(); s.wrReq = 2'b01; s.wa0 = 7'(a); s.wd0 = $urandom;
      if (a == 9) s.wd0 = 32'h7;
      cycle(s, wg, rg);
    end
    cycle(idle(), wg, rg);

    // Same-cycle write/read to one address returns the old word; next cycle returns the new one.
    s = idle(); s.wrReq = 2'b10; s.wa1 = 7'd9; s.wd1 = 32'h1; s.rdReq = 2'b01; s.ra0 = 7'd9;
    cycle(s, wg, rg);
    s = idle(); s.rdReq = 2'b10; s.ra1 = 7'd9;
    cycle(s, wg, rg);
    chk("t4_old_valid", 32'(rd_valid), 32'h1);
    chk("t4_old_data",  rd_data,       32'h7);
    cycle(idle(), wg, rg);
    chk("t4_new_valid", 32'(rd_valid), 32'h2);
    chk("t4_new_data",  rd_data,       32'h1);
    cycle(idle(), wg, rg);
    chk("t4_hold_data", rd_data,       32'h1);

    // Table-driven contention from reset.
    doReset();
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].s, wg, rg);
      chk($sformatf("vec%0d_wg", i), 32'(wg), 32'(vecs[i].expWg));
      chk($sformatf("vec%0d_rg", i), 32'(rg), 32'(vecs[i].expRg));
    end

    // Reset while a read is in flight discards it and restores client-0 priority.
    s = idle(); s.rdReq = 2'b10; s.ra1 = 7'd3;
    cycle(s, wg, rg);
    doReset();
    s = idle(); s.rdReq = 2'b11; s.ra0 = 7'd4; s.ra1 = 7'd5;
    cycle(s, wg, rg);
    chk("t5_first_gnt", 32'(rg), 32'h1);
    for (int i = 0; i < 3; i++) cycle(idle(), wg, rg);

    // Lone requester streams with no bubbles.
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.rdReq = 2'b10; s.ra1 = 7'($urandom);
      cycle(s, wg, rg);
      chk("t6_gnt", 32'(rg), 32'h2);
      if (i >= 2) chk("t6_valid", 32'(rd_valid), 32'h2);
    end
    cycle(idle(), wg, rg);
    cycle(idle(), wg, rg);

    // Random traffic on both ports.
    for (int i = 0; i < 400; i++) begin
      s.wrReq = 2'($urandom_range(0, 3));
      s.rdReq = 2'($urandom_range(0, 3));
      s.wa0 = 7'($urandom); s.wa1 = 7'($urandom);
      s.ra0 = 7'($urandom); s.ra1 = 7'($urandom);
      s.wd0 = $urandom;     s.wd1 = $urandom;
      cycle(s, wg, rg);
    end
    cycle(idle(), wg, rg);
    cycle(idle(), wg, rg);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
